// File: rtl/muldiv_iter_pkg.sv
// Shared M-extension encodings, decoder constant and FSM state type for the
// iterative multiply/divide unit.
package muldiv_iter_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Start/done request bus between the execute stage and the mul/div unit.
interface muldiv_iter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic              start;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [TAG_W-1:0]  tag_in;
  logic              flush;
  logic              ready;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output start, funct3, rs1, rs2, tag_in, flush,
    input  ready, busy, done, result, tag_out
  );

  modport slave (
    input  start, funct3, rs1, rs2, tag_in, flush,
    output ready, busy, done, result, tag_out
  );
endinterface

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt,
  output logic            qbit
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] sub;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    rem_sh = {hi, lo[XLEN-1]};
    // true difference is below 2^XLEN whenever it is kept, so modulo subtract suffices
    sub    = rem_sh[XLEN-1:0] - opb;
    qbit   = is_div & (rem_sh >= {1'b0, opb});
    lo_nxt = {sum[0], lo[XLEN-1:1]};
    if (is_div) hi_nxt = qbit ? sub : rem_sh[XLEN-1:0];
    else        hi_nxt = sum[XLEN:1];
  end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit, one bit per clock, magnitude
// arithmetic with sign fix-up at accept and in the final cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift-add / shift-subtract step per cycle
// FIX   | sign correction, half/quotient/remainder select, result register
// DONE  | one-cycle done pulse, can accept the next op
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_iter_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  muldiv_state_t     state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [TAG_W-1:0]  tag;
  logic              neg_res;
  logic              special;
  logic [XLEN-1:0]   hi, lo, opb;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_q;

  logic              sa, sb, div0, ovf, spec_in;
  logic [XLEN-1:0]   a_mag, b_mag, spec_val;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, fix_res;
  logic [XLEN-1:0]   hi_nxt, mul_lo;
  logic              qbit;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (op[2]),
    .hi     (hi),
    .lo     (lo),
    .opb    (opb),
    .hi_nxt (hi_nxt),
    .lo_nxt (mul_lo),
    .qbit   (qbit)
  );

  always_comb begin
    sa       = a_signed(bus.funct3) & bus.rs1[XLEN-1];
    sb       = b_signed(bus.funct3) & bus.rs2[XLEN-1];
    a_mag    = sa ? (~bus.rs1 + 1'b1) : bus.rs1;
    b_mag    = sb ? (~bus.rs2 + 1'b1) : bus.rs2;
    div0     = (bus.rs2 == '0);
    ovf      = ((bus.funct3 == MD_DIV) || (bus.funct3 == MD_REM)) &&
               (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2);
    spec_in  = bus.funct3[2] & (div0 | ovf);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (bus.funct3[1]) spec_val = div0 ? bus.rs1 : '0;
    else               spec_val = div0 ? '1 : bus.rs1;

    prod     = {hi, lo};
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    q_fix    = neg_res ? (~lo + 1'b1) : lo;
    r_fix    = neg_res ? (~hi + 1'b1) : hi;
    case (op)
      MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = q_fix;
      default:                      fix_res = r_fix;
    endcase
    if (special) fix_res = lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      tag      <= '0;
      neg_res  <= 1'b0;
      special  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            op      <= bus.funct3;
            tag     <= bus.tag_in;
            neg_res <= (bus.funct3 == MD_REM) ? sa : (sa ^ sb);
            special <= spec_in;
            cnt     <= CW'(XLEN);
            hi      <= '0;
            lo      <= spec_in ? spec_val : a_mag;
            opb     <= b_mag;
            state   <= spec_in ? FIX : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          hi  <= hi_nxt;
          lo  <= op[2] ? {lo[XLEN-2:0], qbit} : mul_lo;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          tag_q    <= tag;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready   = (state == IDLE) || (state == DONE);
  assign bus.busy    = (state == CALC) || (state == FIX);
  assign bus.done    = (state == DONE);
  assign bus.result  = result_q;
  assign bus.tag_out = tag_q;
endmodule
